flow_level_meter: RTL and testbench

Upstream stage of the spirometer control state machine. Converts the raw airflow sensor samples into the 3-bit LED effort level that the state machine compares against its targets (level 3 advances the test). Operation: baseline calibration, sliding-window averaging, weight-scaled thresholds, and a peak-hold on the displayed level.

---
 rtl/flow_meter_pkg.sv | 28 ++
 rtl/flow_avg_window.sv | 48 ++++
 rtl/flow_level_meter.sv | 144 ++++++++++++++
 tb/tb_flow_level_meter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_meter_pkg.sv
// Shared types, constants and threshold helper for the airflow effort-level meter.
package flow_meter_pkg;

  typedef enum logic {
    CAL = 1'b0,
    RUN = 1'b1
  } meterState_t;

  localparam int LED_MAX     = 7;
  localparam int STEP_OFFSET = 16;
  localparam int LEVEL_W     = 3;
  localparam int STEP_W      = 11;
  localparam int CMP_W       = 14;

  // Level = number of thresholds k*step (k = 1..LED_MAX) the average reaches.
  function automatic logic [LEVEL_W-1:0] calcLevel(input logic [CMP_W-1:0] avg,
                                                   input logic [7:0]       peso);
    logic [STEP_W-1:0]  step;
    logic [LEVEL_W-1:0] lvl;
    step = {1'b0, peso, 2'b00} + STEP_W'(STEP_OFFSET);
    lvl  = '0;
    for (int k = 1; k <= LED_MAX; k++) begin
      if (avg >= CMP_W'(k) * CMP_W'(step)) lvl = lvl + LEVEL_W'(1);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/flow_avg_window.sv
// Sliding window of the last 2^AVG_LOG2 net samples with a running sum.
module flow_avg_window
  import flow_meter_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic                         iClk,
  input  logic                         iReset_n,
  input  logic                         iCE,
  input  logic                         iClear,
  input  logic                         iValid,
  input  logic [SAMPLE_W-1:0]          ivIn,
  output logic [SAMPLE_W+AVG_LOG2-1:0] ovSum,
  output logic                         oSumValid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = SAMPLE_W + AVG_LOG2;

  logic [SAMPLE_W-1:0] winBuf [DEPTH];
  logic [AVG_LOG2-1:0] wrPtr;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < DEPTH; i++) winBuf[i] <= '0;
      wrPtr     <= '0;
      ovSum     <= '0;
      oSumValid <= 1'b0;
    end else if (iCE) begin
      if (iClear) begin
        for (int i = 0; i < DEPTH; i++) winBuf[i] <= '0;
        wrPtr     <= '0;
        ovSum     <= '0;
        oSumValid <= 1'b0;
      end else begin
        oSumValid <= iValid;
        if (iValid) begin
          // Intermediate may wrap; the final sum of DEPTH entries always fits.
          ovSum          <= ovSum + SUM_W'(ivIn) - SUM_W'(winBuf[wrPtr]);
          winBuf[wrPtr]  <= ivIn;
          wrPtr          <= wrPtr + AVG_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: rtl/flow_level_meter.sv
// Airflow sample to 3-bit LED effort level: baseline calibration, window average, thresholds.
// Optional peak hold on ovLED is enabled by defining FLOW_PEAK_HOLD_EN.
//
// state | meaning
// CAL   | accumulating 2^AVG_LOG2 raw samples to form the baseline
// RUN   | baseline-subtracted samples feed the window and level output
module flow_level_meter
  import flow_meter_pkg::*;
#(
  parameter int SAMPLE_W   = 12,
  parameter int AVG_LOG2   = 3,
  parameter int HOLD_TICKS = 1000
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic                iCE,
  input  logic                iSample_Valid,
  input  logic [SAMPLE_W-1:0] ivSample,
  input  logic                iCal,
  input  logic [7:0]          ivPeso,
  output logic [LEVEL_W-1:0]  ovLED,
  output logic                oLevel_Valid,
  output logic                oCal_Busy
);

  localparam int SUM_W = SAMPLE_W + AVG_LOG2;

  meterState_t         state;
  logic [AVG_LOG2-1:0] calCnt;
  logic [SUM_W-1:0]    calSum;
  logic [SUM_W-1:0]    calTotal;
  logic [SAMPLE_W-1:0] baseline;
  logic [SAMPLE_W:0]   netDiff;
  logic [SAMPLE_W-1:0] netSample;
  logic                accept;
  logic                calReq;
  logic                winValid;
  logic                winClear;
  logic [SUM_W-1:0]    winSum;
  logic                sumValid;
  logic [LEVEL_W-1:0]  levelNext;

  assign accept    = iCE & iSample_Valid;
  assign calReq    = iCE & iCal;
  assign calTotal  = calSum + SUM_W'(ivSample);
  assign netDiff   = {1'b0, ivSample} - {1'b0, baseline};
  assign netSample = netDiff[SAMPLE_W] ? '0 : netDiff[SAMPLE_W-1:0];
  assign winValid  = (state == RUN) & accept & ~iCal;
  // Window is emptied on entry to RUN and whenever recalibration starts.
  assign winClear  = (state == RUN) ? calReq : (accept & ~iCal & (calCnt == '1));
  assign levelNext = calcLevel(CMP_W'(winSum >> AVG_LOG2), ivPeso);

  flow_avg_window #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) uWindow (
    .iClk      (iClk),
    .iReset_n  (iReset_n),
    .iCE       (iCE),
    .iClear    (winClear),
    .iValid    (winValid),
    .ivIn      (netSample),
    .ovSum     (winSum),
    .oSumValid (sumValid)
  );

`ifdef FLOW_PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  logic [HOLD_W-1:0] holdCnt;
`endif

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state        <= CAL;
      calCnt       <= '0;
      calSum       <= '0;
      baseline     <= '0;
      ovLED        <= '0;
      oLevel_Valid <= 1'b0;
      oCal_Busy    <= 1'b1;
`ifdef FLOW_PEAK_HOLD_EN
      holdCnt      <= '0;
`endif
    end else if (!iCE) begin
      oLevel_Valid <= 1'b0;
    end else begin
      oLevel_Valid <= 1'b0;
      case (state)
        CAL: begin
          if (iCal) begin
            calCnt <= '0;
            calSum <= '0;
          end else if (iSample_Valid) begin
            if (calCnt == '1) begin
              baseline  <= SAMPLE_W'(calTotal >> AVG_LOG2);
              calCnt    <= '0;
              calSum    <= '0;
              state     <= RUN;
              oCal_Busy <= 1'b0;
            end else begin
              calCnt <= calCnt + AVG_LOG2'(1);
              calSum <= calTotal;
            end
          end
        end
        RUN: begin
          if (iCal) begin
            state     <= CAL;
            oCal_Busy <= 1'b1;
            calCnt    <= '0;
            calSum    <= '0;
            ovLED     <= '0;
`ifdef FLOW_PEAK_HOLD_EN
            holdCnt   <= '0;
`endif
          end else begin
            oLevel_Valid <= sumValid;
`ifdef FLOW_PEAK_HOLD_EN
            // A higher level beats an expiry landing in the same tick.
            if (sumValid && (levelNext > ovLED)) begin
              ovLED   <= levelNext;
              holdCnt <= HOLD_LOAD;
            end else if (ovLED != '0) begin
              if (holdCnt <= HOLD_W'(1)) begin
                ovLED   <= ovLED - LEVEL_W'(1);
                holdCnt <= HOLD_LOAD;
              end else begin
                holdCnt <= holdCnt - HOLD_W'(1);
              end
            end else if (holdCnt != '0) begin
              holdCnt <= holdCnt - HOLD_W'(1);
            end
`else
            if (sumValid) ovLED <= levelNext;
`endif
          end
        end
        default: state <= CAL;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_level_meter.sv
// Self-checking bench for flow_level_meter against a queue-based behavioural model.
module tb_flow_level_meter;

  localparam int HOLD = 4;

  logic       iClk = 1'b0;
  logic       iReset_n;
  logic       iCE;
  logic       iSample_Valid;
  logic [11:0] ivSample;
  logic       iCal;
  logic [7:0] ivPeso;
  logic [2:0] ovLED;
  logic       oLevel_Valid;
  logic       oCal_Busy;

  int nChecks = 0;
  int nFail   = 0;

  flow_level_meter #(
    .SAMPLE_W   (12),
    .AVG_LOG2   (3),
    .HOLD_TICKS (HOLD)
  ) dut (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iCE           (iCE),
    .iSample_Valid (iSample_Valid),
    .ivSample      (ivSample),
    .iCal          (iCal),
    .ivPeso        (ivPeso),
    .ovLED         (ovLED),
    .oLevel_Valid  (oLevel_Valid),
    .oCal_Busy     (oCal_Busy)
  );

  always #5 iClk = ~iClk;

  // Behavioural model state (values visible after each rising edge).
  bit mCal;
  int mCalCnt, mCalSum, mBase;
  int mWin[$];
  bit mS1Valid;
  int mS1Avg;
  int mLed;
  bit mValid;
  int mHold;

  function automatic int refLevel(int avg, int peso);
    int step = peso * 4 + 16;
    int l = 0;
    for (int k = 1; k <= 7; k++) if (avg >= k * step) l++;
    return l;
  endfunction

  task automatic modelReset();
    mCal = 1; mCalCnt = 0; mCalSum = 0; mBase = 0;
    mWin = {0, 0, 0, 0, 0, 0, 0, 0};
    mS1Valid = 0; mS1Avg = 0; mLed = 0; mValid = 0; mHold = 0;
  endtask

  task automatic modelEdge(bit ce, bit v, int s, bit cal);
    int lvl, sum, net;
    bit nv;
    if (!ce) begin
      mValid = 0;
      return;
    end
    nv = 0; lvl = 0;
    if (!mCal && mS1Valid && !cal) begin
      nv  = 1;
      lvl = refLevel(mS1Avg, int'(ivPeso));
    end
    mValid = nv;
    if (!mCal && cal) begin
      mLed = 0; mHold = 0;
    end else if (!mCal) begin
`ifdef FLOW_PEAK_HOLD_EN
      if (nv && lvl > mLed) begin
        mLed = lvl; mHold = HOLD;
      end else if (mLed > 0) begin
        if (mHold <= 1) begin mLed--; mHold = HOLD; end
        else mHold--;
      end else if (mHold > 0) mHold--;
`else
      if (nv) mLed = lvl;
`endif
    end
    if (mCal) begin
      mS1Valid = 0;
      if (cal) begin
        mCalCnt = 0; mCalSum = 0;
      end else if (v) begin
        if (mCalCnt == 7) begin
          mBase = (mCalSum + s) / 8;
          mWin  = {0, 0, 0, 0, 0, 0, 0, 0};
          mCal  = 0; mCalCnt = 0; mCalSum = 0;
        end else begin
          mCalCnt++; mCalSum += s;
        end
      end
    end else if (cal) begin
      mCal = 1; mCalCnt = 0; mCalSum = 0; mS1Valid = 0;
    end else begin
      mS1Valid = v;
      if (v) begin
        net = (s > mBase) ? s - mBase : 0;
        void'(mWin.pop_front());
        mWin.push_back(net);
        sum = 0;
        foreach (mWin[i]) sum += mWin[i];
        mS1Avg = sum / 8;
      end
    end
  endtask

  // Drive one cycle from a falling edge, update the model at the rising edge.
  task automatic step(bit ce, bit v, int s, bit cal);
    iCE = ce; iSample_Valid = v; ivSample = 12'(s); iCal = cal;
    @(posedge iClk);
    modelEdge(ce, v, s, cal);
    @(negedge iClk);
  endtask

  task automatic doReset();
    iReset_n = 1'b0; iCE = 1'b0; iSample_Valid = 1'b0; ivSample = '0;
    iCal = 1'b0; ivPeso = '0;
    modelReset();
    repeat (2) @(negedge iClk);
    iReset_n = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    nChecks++;
    if (ovLED !== 3'd0 || oLevel_Valid !== 1'b0 || oCal_Busy !== 1'b1) begin
      nFail++;
      $display("FAIL reset: led=%0d valid=%0b busy=%0b, required 0/0/1", ovLED, oLevel_Valid, oCal_Busy);
    end
  endtask

  task automatic test_cal_baseline();
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 200, 0);
      nChecks++;
      if (oCal_Busy !== (i < 7) || oCal_Busy !== mCal) begin
        nFail++;
        $display("FAIL cal_busy[%0d]: busy=%0b required=%0b", i, oCal_Busy, (i < 7));
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 200, 0);
      nChecks++;
      if (ovLED !== 3'd0 || oLevel_Valid !== (i >= 1) || oLevel_Valid !== mValid) begin
        nFail++;
        $display("FAIL cal_zero[%0d]: led=%0d valid=%0b required 0/%0b", i, ovLED, oLevel_Valid, (i >= 1));
      end
    end
  endtask

  task automatic recal(int base);
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 1, base, 0);
  endtask

  task automatic test_level3();
    ivPeso = 8'd0;
    recal(200);
    for (int i = 0; i < 10; i++) begin
      step(1, (i < 8), 248, 0);
      nChecks++;
      if (ovLED !== mLed[2:0] || oLevel_Valid !== mValid || oCal_Busy !== 1'b0) begin
        nFail++;
        $display("FAIL level3_stream[%0d]: led=%0d valid=%0b required %0d/%0b", i, ovLED, oLevel_Valid, mLed, mValid);
      end
    end
    nChecks++;
    if (ovLED !== 3'd3) begin
      nFail++;
      $display("FAIL level3_final: led=%0d required 3", ovLED);
    end
  endtask

  task automatic test_saturate();
    recal(200);
    for (int i = 0; i < 10; i++) step(1, (i < 8), 100, 0);
    nChecks++;
    if (ovLED !== 3'd0 || mLed != 0) begin
      nFail++;
      $display("FAIL saturate: led=%0d required 0", ovLED);
    end
  endtask

  task automatic test_clamp();
    ivPeso = 8'd255;
    recal(0);
    for (int i = 0; i < 10; i++) step(1, (i < 8), 4095, 0);
    nChecks++;
    if (ovLED !== 3'd3) begin
      nFail++;
      $display("FAIL clamp_peso255: led=%0d required 3", ovLED);
    end
    ivPeso = 8'd0;
    step(1, 1, 4095, 0);
    step(1, 0, 0, 0);
    nChecks++;
    if (ovLED !== 3'd7 || oLevel_Valid !== 1'b1) begin
      nFail++;
      $display("FAIL clamp_peso0: led=%0d valid=%0b required 7/1", ovLED, oLevel_Valid);
    end
  endtask

  task automatic test_cal_drop();
    ivPeso = 8'd0;
    recal(200);
    for (int i = 0; i < 10; i++) step(1, 1, 248, 0);
    nChecks++;
    if (ovLED !== 3'd3) begin
      nFail++;
      $display("FAIL drop_pre: led=%0d required 3", ovLED);
    end
    step(1, 1, 248, 1);
    nChecks++;
    if (oCal_Busy !== 1'b1 || ovLED !== 3'd0 || oLevel_Valid !== 1'b0) begin
      nFail++;
      $display("FAIL drop_cal: busy=%0b led=%0d valid=%0b required 1/0/0", oCal_Busy, ovLED, oLevel_Valid);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 200, 0);
      nChecks++;
      if (oCal_Busy !== (i < 7) || oLevel_Valid !== 1'b0) begin
        nFail++;
        $display("FAIL drop_recal[%0d]: busy=%0b valid=%0b required %0b/0", i, oCal_Busy, oLevel_Valid, (i < 7));
      end
    end
  endtask

`ifdef FLOW_PEAK_HOLD_EN
  task automatic test_peak_hold();
    ivPeso = 8'd0;
    recal(0);
    for (int i = 0; i < 10; i++) step(1, (i < 8), 88, 0);
    nChecks++;
    if (ovLED !== 3'd5) begin
      nFail++;
      $display("FAIL hold_reach5: led=%0d required 5", ovLED);
    end
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 0);
      nChecks++;
      if (ovLED !== mLed[2:0] || oLevel_Valid !== mValid) begin
        nFail++;
        $display("FAIL hold_decay[%0d]: led=%0d valid=%0b required %0d/%0b", i, ovLED, oLevel_Valid, mLed, mValid);
      end
    end
    nChecks++;
    if (ovLED !== 3'd0) begin
      nFail++;
      $display("FAIL hold_zero: led=%0d required 0", ovLED);
    end
    recal(0);
    for (int i = 0; i < 10; i++) step(1, (i < 8), 88, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 200, 0);
      nChecks++;
      if (ovLED !== mLed[2:0] || oLevel_Valid !== mValid) begin
        nFail++;
        $display("FAIL hold_rise[%0d]: led=%0d valid=%0b required %0d/%0b", i, ovLED, oLevel_Valid, mLed, mValid);
      end
    end
    nChecks++;
    if (ovLED !== 3'd6) begin
      nFail++;
      $display("FAIL hold_six: led=%0d required 6", ovLED);
    end
  endtask
`endif

  task automatic test_random();
    int base;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) ivPeso = 8'($urandom_range(0, 40));
      base = mCal ? $urandom_range(0, 300) : $urandom_range(0, 4095);
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), base,
           ($urandom_range(0, 149) == 0));
      nChecks++;
      if (ovLED !== mLed[2:0] || oLevel_Valid !== mValid || oCal_Busy !== mCal) begin
        nFail++;
        $display("FAIL random[%0d]: led=%0d valid=%0b busy=%0b required %0d/%0b/%0b",
                 i, ovLED, oLevel_Valid, oCal_Busy, mLed, mValid, mCal);
      end
    end
  endtask

  task automatic test_async_reset();
    ivPeso = 8'd0;
    recal(0);
    for (int i = 0; i < 8; i++) step(1, 1, 120, 0);
    #2 iReset_n = 1'b0;
    #1;
    nChecks++;
    if (ovLED !== 3'd0 || oLevel_Valid !== 1'b0 || oCal_Busy !== 1'b1) begin
      nFail++;
      $display("FAIL async_reset: led=%0d valid=%0b busy=%0b required 0/0/1", ovLED, oLevel_Valid, oCal_Busy);
    end
    modelReset();
    @(negedge iClk);
    iReset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 40, 0);
      nChecks++;
      if (ovLED !== mLed[2:0] || oLevel_Valid !== mValid || oCal_Busy !== mCal) begin
        nFail++;
        $display("FAIL post_reset[%0d]: led=%0d valid=%0b busy=%0b required %0d/%0b/%0b",
                 i, ovLED, oLevel_Valid, oCal_Busy, mLed, mValid, mCal);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cal_baseline();
    test_level3();
    test_saturate();
    test_clamp();
    test_cal_drop();
`ifdef FLOW_PEAK_HOLD_EN
    test_peak_hold();
`endif
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
